aes_key_expansion: RTL and testbench
====================================

Name: aes_key_expansion

Overview:
- Sequential AES-128 key schedule. Produces the round-key stream consumed by the AddRoundKey stage.
- Accepts a 128-bit cipher key over a valid/ready handshake.
- Emits round keys 0..10 one per handshake in encryption order, or 10..0 in decryption order.
- Decryption order is produced by the inverse key recurrence, so no 11-entry key store is needed.

Parameters:
- NR, 10, number of rounds. Fixed at 10 for AES-128; any other value is illegal.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_key  input  128  cipher key; bits 127:120 are key byte 0
- i_dec  input  1  sampled with i_key. 0 = emit rounds 0..10; 1 = emit rounds 10..0
- i_key_valid  input  1  key load request
- o_key_ready  output  1  block idle and able to accept a key
- o_rk  output  128  round key; bits 127:96 = word w0, MSB byte first
- o_rk_round  output  4  round index of o_rk
- o_rk_last  output  1  o_rk is the final key of the sequence (round 10 for enc, round 0 for dec)
- o_rk_valid  output  1  o_rk is valid
- i_rk_ready  input  1  consumer accepts o_rk

Behaviour:
- Interface (decided): one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_rk = 0, o_rk_round = 0, o_rk_last = 0, o_rk_valid = 0. State is IDLE, so o_key_ready = 1.
- o_key_ready is 1 only in IDLE.
- States:
  - IDLE: on i_key_valid && o_key_ready, latch i_key and i_dec.
    - i_dec = 0: go to EMIT with o_rk = key, round 0, o_rk_valid = 1 on the next cycle.
    - i_dec = 1: go to PRECOMP with round counter = 0.
  - PRECOMP: one forward step per cycle into an internal register; nothing visible on the output. After exactly 10 cycles, go to EMIT with o_rk = rk10, round 10, o_rk_valid = 1.
  - EMIT: o_rk, o_rk_round and o_rk_last stay stable while o_rk_valid && !i_rk_ready.
    - On a handshake of a non-last key, load the next key (forward or inverse step) the next cycle, with o_rk_valid held at 1. The consumer therefore sees one key per cycle under a continuous i_rk_ready.
    - On the handshake of the last key: o_rk_valid drops to 0, go to IDLE, o_key_ready = 1 the next cycle.
- Latency from key-accept edge to first o_rk_valid: enc 1 cycle; dec 11 cycles (10 PRECOMP + 1).
- Forward step, round r = 1..10, previous words p0..p3:
  - t = SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
  - w0 = p0 ^ t; w1 = p1 ^ w0; w2 = p2 ^ w1; w3 = p3 ^ w2
- Inverse step, from rk_r words w0..w3 to rk_(r-1):
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
- RotWord rotates bytes left: [a,b,c,d] -> [b,c,d,a]. SubWord applies the FIPS-197 S-box per byte via an internal table.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- One shared 4-S-box SubWord path serves both the forward and inverse steps (mux on mode).
- i_key_valid outside IDLE is ignored; no key is latched and no error is flagged.
- i_key and i_dec changes outside the accept edge have no effect.
- i_rk_ready while o_rk_valid = 0 has no effect.
- Reset asserted mid-sequence (PRECOMP or EMIT): outputs clear immediately and asynchronously, the sequence is discarded, and the block is in IDLE after deassertion.
- The round counter never wraps. EMIT always terminates at round 10 (enc) or round 0 (dec).

Test Plan:
- Enc, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, i_rk_ready held 1:
  - o_rk round 0 = the key, round 1 = a0fafe1788542cb123a339392a6c7605, round 2 = f2c295f27a96b9435935807a7359f67f, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles; o_rk_last only on round 10; o_key_ready returns 1 the cycle after.
- Dec, same key:
  - o_rk_valid first rises 11 cycles after the accept edge, with round 10 = d014f9a8…0ca6.
  - Then round 1 = a0fafe17…6c7605 and round 0 = 2b7e1516…09cf4f3c.
  - o_rk_last on round 0.
- Backpressure: random i_rk_ready at 30% duty.
  - o_rk and o_rk_round are stable while stalled.
  - The sequence is identical to the no-stall run; exactly 11 handshakes.
- i_key_valid pulsed with a different key during EMIT and PRECOMP: ignored; the original sequence completes unchanged.
- i_rst_n asserted asynchronously mid-EMIT (at round 5):
  - o_rk_valid, o_rk, o_rk_round and o_rk_last drop to 0 with no clock edge; o_key_ready = 1.
  - A fresh key then produces the correct sequence.
- Back-to-back loads: enc key A, then a dec load of key 000102030405060708090a0b0c0d0e0f accepted the cycle o_key_ready rises. Dec round 10 = 13111d7fe3944a17f307a78b4d2b30c5.

Source files
------------

// File: rtl/aes_key_expansion.sv
// Sequential AES-128 key schedule: streams round keys 0..10 (encrypt) or 10..0 (decrypt).
// Decrypt order runs the forward schedule to rk10 first, then walks back with the inverse recurrence.
module aes_key_expansion #(
  parameter int NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_key,
  input  logic         i_dec,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  output logic [127:0] o_rk,
  output logic [3:0]   o_rk_round,
  output logic         o_rk_last,
  output logic         o_rk_valid,
  input  logic         i_rk_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the payload is held stable while valid && !ready.
  typedef enum logic [1:0] {IDLE, PRECOMP, EMIT} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t       state, state_next;
  logic [127:0] cur, cur_next;
  logic [3:0]   rnd, rnd_next;
  logic         dec, dec_next;
  logic         valid, valid_next;

  logic         fwd_mode, is_last, hs;
  logic [31:0]  c0, c1, c2, c3, sub_in, sub_out, t;
  logic [3:0]   rcon_idx;
  logic [127:0] step;

  assign {c0, c1, c2, c3} = cur;

  // PRECOMP always steps forward; in EMIT the direction follows the latched mode.
  assign fwd_mode = (state == PRECOMP) || !dec;
  assign sub_in   = fwd_mode ? c3 : (c3 ^ c2);
  assign rcon_idx = fwd_mode ? (rnd + 4'd1) : rnd;
  assign sub_out  = {SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]], SBOX[sub_in[31:24]]};
  assign t        = sub_out ^ {rcon(rcon_idx), 24'h0};

  always_comb begin
    step = '0;
    if (fwd_mode) begin
      step[127:96] = c0 ^ t;
      step[95:64]  = c1 ^ step[127:96];
      step[63:32]  = c2 ^ step[95:64];
      step[31:0]   = c3 ^ step[63:32];
    end else begin
      step = {c0 ^ t, c1 ^ c0, c2 ^ c1, c3 ^ c2};
    end
  end

  assign is_last = dec ? (rnd == 4'd0) : (rnd == 4'(NR));
  assign hs      = valid && i_rk_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cur   <= '0;
      rnd   <= '0;
      dec   <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      cur   <= cur_next;
      rnd   <= rnd_next;
      dec   <= dec_next;
      valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    cur_next   = cur;
    rnd_next   = rnd;
    dec_next   = dec;
    valid_next = valid;
    case (state)
      IDLE: begin
        if (i_key_valid) begin
          cur_next = i_key;
          dec_next = i_dec;
          rnd_next = 4'd0;
          if (i_dec) begin
            state_next = PRECOMP;
          end else begin
            state_next = EMIT;
            valid_next = 1'b1;
          end
        end
      end
      PRECOMP: begin
        cur_next = step;
        rnd_next = rnd + 4'd1;
        if (rnd == 4'(NR - 1)) begin
          state_next = EMIT;
          valid_next = 1'b1;
        end
      end
      EMIT: begin
        if (hs) begin
          if (is_last) begin
            state_next = IDLE;
            valid_next = 1'b0;
          end else begin
            cur_next = step;
            rnd_next = dec ? (rnd - 4'd1) : (rnd + 4'd1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The working register doubles as the output; it is masked while nothing is offered.
  assign o_rk        = valid ? cur : '0;
  assign o_rk_round  = valid ? rnd : '0;
  assign o_rk_last   = valid && is_last;
  assign o_rk_valid  = valid;
  assign o_key_ready = (state == IDLE);

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: random keys and stalls checked against a FIPS-197 style
// full-schedule model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expansion;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [127:0] i_key = '0;
  logic         i_dec = 1'b0;
  logic         i_key_valid = 1'b0;
  logic         o_key_ready;
  logic [127:0] o_rk;
  logic [3:0]   o_rk_round;
  logic         o_rk_last;
  logic         o_rk_valid;
  logic         i_rk_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] mdl_rk [11];
  logic [127:0] got_rk [11];
  logic [127:0] exp_q [$];
  logic [3:0]   exp_r_q [$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expansion #(.NR(10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key(i_key), .i_dec(i_dec),
    .i_key_valid(i_key_valid), .o_key_ready(o_key_ready), .o_rk(o_rk),
    .o_rk_round(o_rk_round), .o_rk_last(o_rk_last), .o_rk_valid(o_rk_valid),
    .i_rk_ready(i_rk_ready)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = sub_rot(tmp) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] key, input logic dec, output int waited);
    waited = 0;
    @(negedge i_clk);
    while (!o_key_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    checks++;
    if (o_key_ready !== 1'b1) $display("FAIL load_wait: o_key_ready got %b exp 1", o_key_ready);
    i_key = key;
    i_dec = dec;
    i_key_valid = 1'b1;
    @(negedge i_clk);
    i_key_valid = 1'b0;
    i_key = {$urandom, $urandom, $urandom, $urandom};
    i_dec = ~dec;
  endtask

  // Consumes one full sequence; entered on the first falling edge after the accept edge.
  task automatic collect(input logic [127:0] key, input logic dec, input int pct,
                         input bit junk, input string name);
    logic [127:0] held_rk;
    logic [3:0]   held_r;
    bit           stalled = 0;
    bit           seen = 0;
    int           cyc = 1;
    int           err0 = errors;
    expand(key);
    exp_q.delete();
    exp_r_q.delete();
    for (int r = 0; r < 11; r++) begin
      int k;
      k = dec ? 10 - r : r;
      exp_q.push_back(mdl_rk[k]);
      exp_r_q.push_back(4'(k));
    end
    while (exp_q.size() > 0 && cyc < 400) begin
      i_key_valid = junk && (cyc == 3 || cyc == 14);
      if (i_key_valid) begin
        i_key = {$urandom, $urandom, $urandom, $urandom};
        i_dec = ~dec;
      end
      if (!o_rk_valid) begin
        checks++;
        if (seen) begin
          $display("FAIL %s valid_drop: o_rk_valid got 0 exp 1 at cyc %0d", name, cyc);
          errors++;
        end
        i_rk_ready = ($urandom_range(0, 99) < pct);
        stalled = 0;
      end else begin
        if (!seen) begin
          checks++;
          if (cyc != (dec ? 11 : 1)) begin
            $display("FAIL %s latency: got %0d exp %0d", name, cyc, dec ? 11 : 1);
            errors++;
          end
          seen = 1;
        end
        if (stalled) begin
          checks++;
          if (o_rk !== held_rk || o_rk_round !== held_r) begin
            $display("FAIL %s stall_hold: got %h r%0d exp %h r%0d", name, o_rk, o_rk_round, held_rk, held_r);
            errors++;
          end
        end
        checks++;
        if (o_key_ready !== 1'b0) begin
          $display("FAIL %s busy_ready: o_key_ready got %b exp 0", name, o_key_ready);
          errors++;
        end
        i_rk_ready = ($urandom_range(0, 99) < pct);
        if (i_rk_ready) begin
          checks++;
          if (o_rk !== exp_q[0] || o_rk_round !== exp_r_q[0] || o_rk_last !== (exp_q.size() == 1)) begin
            $display("FAIL %s rk: got %h r%0d last %b exp %h r%0d last %b", name, o_rk, o_rk_round,
                     o_rk_last, exp_q[0], exp_r_q[0], exp_q.size() == 1);
            errors++;
          end
          got_rk[exp_r_q[0]] = o_rk;
          void'(exp_q.pop_front());
          void'(exp_r_q.pop_front());
          stalled = 0;
        end else begin
          stalled = 1;
          held_rk = o_rk;
          held_r  = o_rk_round;
        end
      end
      if (exp_q.size() > 0) @(negedge i_clk);
      cyc++;
    end
    i_key_valid = 1'b0;
    checks++;
    if (exp_q.size() > 0) begin
      $display("FAIL %s timeout: %0d keys outstanding, exp 0", name, exp_q.size());
      errors++;
    end else begin
      @(posedge i_clk);
      #1;
      if (o_rk_valid !== 1'b0 || o_key_ready !== 1'b1) begin
        $display("FAIL %s end_idle: valid %b ready %b exp 0 1", name, o_rk_valid, o_key_ready);
        errors++;
      end
    end
    i_rk_ready = 1'b0;
    if (errors != err0) $display("note: %s had %0d errors", name, errors - err0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (o_rk !== '0 || o_rk_round !== 4'd0 || o_rk_last !== 1'b0 || o_rk_valid !== 1'b0 || o_key_ready !== 1'b1) begin
      $display("FAIL reset: rk %h r%0d last %b valid %b ready %b exp 0 0 0 0 1",
               o_rk, o_rk_round, o_rk_last, o_rk_valid, o_key_ready);
      errors++;
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic check_kat(input string name, input logic [3:0] r, input logic [127:0] exp);
    checks++;
    if (got_rk[r] !== exp) begin
      $display("FAIL %s r%0d: got %h exp %h", name, r, got_rk[r], exp);
      errors++;
    end
  endtask

  task automatic test_fips_enc();
    int w;
    load_key(FIPS_KEY, 1'b0, w);
    collect(FIPS_KEY, 1'b0, 100, 0, "fips_enc");
    check_kat("fips_enc", 4'd0, FIPS_KEY);
    check_kat("fips_enc", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    check_kat("fips_enc", 4'd2, 128'hf2c295f27a96b9435935807a7359f67f);
    check_kat("fips_enc", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  task automatic test_fips_dec();
    int w;
    load_key(FIPS_KEY, 1'b1, w);
    collect(FIPS_KEY, 1'b1, 100, 0, "fips_dec");
    check_kat("fips_dec", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_kat("fips_dec", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    check_kat("fips_dec", 4'd0, FIPS_KEY);
  endtask

  task automatic test_backpressure();
    int w;
    logic [127:0] k;
    logic d;
    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      d = n[0];
      load_key(k, d, w);
      collect(k, d, 30, 0, d ? "bp_dec" : "bp_enc");
    end
  endtask

  task automatic test_ignore_key();
    int w;
    logic [127:0] k;
    load_key(FIPS_KEY, 1'b1, w);
    collect(FIPS_KEY, 1'b1, 60, 1, "ignore_dec");
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b0, w);
    collect(k, 1'b0, 60, 1, "ignore_enc");
  endtask

  task automatic test_reset_mid();
    int w;
    int n = 0;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b0, w);
    i_rk_ready = 1'b1;
    while (!(o_rk_valid && o_rk_round == 4'd5) && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (!(o_rk_valid && o_rk_round == 4'd5)) begin
      $display("FAIL reset_mid reach: round %0d valid %b exp 5 1", o_rk_round, o_rk_valid);
      errors++;
    end
    #2;
    i_rst_n = 1'b0;
    i_rk_ready = 1'b0;
    #1;
    checks++;
    if (o_rk !== '0 || o_rk_round !== 4'd0 || o_rk_last !== 1'b0 || o_rk_valid !== 1'b0 || o_key_ready !== 1'b1) begin
      $display("FAIL reset_mid clear: rk %h r%0d last %b valid %b ready %b exp 0 0 0 0 1",
               o_rk, o_rk_round, o_rk_last, o_rk_valid, o_key_ready);
      errors++;
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b1, w);
    collect(k, 1'b1, 50, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int w;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k, 1'b0, w);
    collect(k, 1'b0, 100, 0, "b2b_enc");
    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b1, w);
    checks++;
    if (w != 0) begin
      $display("FAIL b2b_accept: waited %0d cycles exp 0", w);
      errors++;
    end
    collect(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 100, 0, "b2b_dec");
    check_kat("b2b_dec", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_enc();
    test_fips_dec();
    test_backpressure();
    test_ignore_key();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
